// File: rtl/cpu_cmd_decoder.sv
// ASCII run-control command decoder: "g<hex>\r" starts the CPU at a PC, "q\r" halts it.
// Optional echo buffer back to the UART TX path is built when CMD_ECHO_EN is defined.

module cpu_cmd_decoder_chk #(
  parameter int ADR_W = 32
) (
  input logic             clk,
  input logic             rst,
  input logic             cpu_start,
  input logic             quit_cmd,
  input logic             cmd_err,
  input logic [ADR_W-1:0] start_adr
);

  a_one_pulse : assert property (@(posedge clk) disable iff (rst)
    $onehot0({cpu_start, quit_cmd, cmd_err}));

  // start_adr may only move together with a cpu_start pulse (or on reset)
  a_adr_stable : assert property (@(posedge clk) disable iff (rst)
    (!cpu_start && !$past(rst)) |-> $stable(start_adr));

endmodule

module cpu_cmd_decoder #(
  parameter int ADR_W   = 32,
  parameter int MAX_HEX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_vld,
  input  logic [7:0]       rx_data,
  input  logic             cpu_stalled,
  output logic             cpu_start,
  output logic             quit_cmd,
  output logic [ADR_W-1:0] start_adr,
  output logic             cmd_err,
  output logic             tx_vld,
  output logic [7:0]       tx_data,
  input  logic             tx_rdy
);

  localparam int CNT_W = $clog2(MAX_HEX + 1);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_G  = 8'h67;
  localparam logic [7:0] CH_GU = 8'h47;
  localparam logic [7:0] CH_Q  = 8'h71;
  localparam logic [7:0] CH_QU = 8'h51;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GO_ADR = 2'd1,
    WAIT_Q = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  state_t             state_r;
  logic [ADR_W-1:0]   shift_r;
  logic [CNT_W-1:0]   cnt_r;

  function automatic logic is_hex(input logic [7:0] c);
    logic r;
    if ((c >= 8'h30) && (c <= 8'h39)) begin
      r = 1'b1;
    end else if ((c >= 8'h41) && (c <= 8'h46)) begin
      r = 1'b1;
    end else if ((c >= 8'h61) && (c <= 8'h66)) begin
      r = 1'b1;
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

  // letters 'A'/'a' both have low nibble 1, so adding 9 yields 10..15
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    logic [3:0] r;
    if (c <= 8'h39) begin
      r = c[3:0];
    end else begin
      r = c[3:0] + 4'd9;
    end
    return r;
  endfunction

  // Command FSM with registered run-control pulses and captured start PC
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      cnt_r     <= '0;
      start_adr <= '0;
      cpu_start <= 1'b0;
      quit_cmd  <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      cpu_start <= 1'b0;
      quit_cmd  <= 1'b0;
      cmd_err   <= 1'b0;
      if (rx_vld) begin
        case (state_r)
          IDLE: begin
            if ((rx_data == CH_G) || (rx_data == CH_GU)) begin
              state_r <= GO_ADR;
              shift_r <= '0;
              cnt_r   <= '0;
            end else if ((rx_data == CH_Q) || (rx_data == CH_QU)) begin
              state_r <= WAIT_Q;
            end else if ((rx_data == CH_CR) || (rx_data == CH_LF) || (rx_data == CH_SP)) begin
              state_r <= IDLE;
            end else begin
              state_r <= FLUSH;
            end
          end
          GO_ADR: begin
            if (is_hex(rx_data)) begin
              if (cnt_r < CNT_W'(MAX_HEX)) begin
                shift_r <= {shift_r[ADR_W-5:0], hex_val(rx_data)};
                cnt_r   <= cnt_r + CNT_W'(1);
              end else begin
                state_r <= FLUSH;
              end
            end else if (rx_data == CH_CR) begin
              state_r <= IDLE;
              if (cnt_r == '0) begin
                cmd_err <= 1'b1;
              end else if (!cpu_stalled) begin
                cmd_err <= 1'b1;
              end else begin
                start_adr <= shift_r;
                cpu_start <= 1'b1;
              end
            end else begin
              state_r <= FLUSH;
            end
          end
          WAIT_Q: begin
            if (rx_data == CH_CR) begin
              quit_cmd <= 1'b1;
              state_r  <= IDLE;
            end else begin
              state_r <= FLUSH;
            end
          end
          FLUSH: begin
            if (rx_data == CH_CR) begin
              cmd_err <= 1'b1;
              state_r <= IDLE;
            end else begin
              state_r <= FLUSH;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef CMD_ECHO_EN
  // One-entry echo buffer; a byte arriving while full is simply not echoed
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_vld  <= 1'b0;
      tx_data <= 8'h00;
    end else if (rx_vld && (!tx_vld || tx_rdy)) begin
      tx_vld  <= 1'b1;
      tx_data <= rx_data;
    end else if (tx_rdy) begin
      tx_vld  <= 1'b0;
    end
  end
`else
  logic unused_tx_rdy;
  assign unused_tx_rdy = tx_rdy;
  assign tx_vld        = 1'b0;
  assign tx_data       = 8'h00;
`endif

  cpu_cmd_decoder_chk #(.ADR_W(ADR_W)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .cpu_start (cpu_start),
    .quit_cmd  (quit_cmd),
    .cmd_err   (cmd_err),
    .start_adr (start_adr)
  );

endmodule
